// File: rtl/rv_pipe_pkg.sv
// Shared RV pipeline encodings: ALU operations, result-source and forward-select codes.
package rv_pipe_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX inputs, forwarding controls, redirect and EX/MEM outputs of the execute stage.
interface execute_stage_if #(parameter int XLEN = 32);
  logic            JumpE, BranchE, ALUSrcE, MemWriteE, RegWriteE;
  logic [1:0]      ResultSrcE;
  logic [2:0]      ALUControlE;
  logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]      RdE;
  logic [1:0]      ForwardAE, ForwardBE;
  logic [XLEN-1:0] ResultW;
  logic            FlushM;

  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic            RegWriteM, MemWriteM;
  logic [1:0]      ResultSrcM;
  logic [XLEN-1:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]      RdM;

  modport master (
    output JumpE, BranchE, ALUSrcE, MemWriteE, RegWriteE, ResultSrcE, ALUControlE,
           RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, ForwardAE, ForwardBE, ResultW, FlushM,
    input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM,
           PCPlus4M, RdM
  );

  modport slave (
    input  JumpE, BranchE, ALUSrcE, MemWriteE, RegWriteE, ResultSrcE, ALUControlE,
           RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, ForwardAE, ForwardBE, ResultW, FlushM,
    output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM,
           PCPlus4M, RdM
  );
endinterface

// File: rtl/execute_stage_alu.sv
// Combinational ALU: add/sub/and/or/signed-slt; unlisted codes yield zero.
module alu
  import rv_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [2:0]      ALUControl,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero
);

  always_comb begin
    ALUResult = '0;
    case (ALUControl)
      ALU_ADD: ALUResult = SrcA + SrcB;
      ALU_SUB: ALUResult = SrcA - SrcB;
      ALU_AND: ALUResult = SrcA & SrcB;
      ALU_OR:  ALUResult = SrcA | SrcB;
      ALU_SLT: ALUResult = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      default: ALUResult = '0;
    endcase
  end

  assign Zero = (ALUResult == '0);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: forwarding muxes, ALU, branch/jump resolution and the EX/MEM register.
module execute_stage
  import rv_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic            CLK,
  input logic            RESET_N,
  execute_stage_if.slave ex
);

  logic [XLEN-1:0] src_a_e, src_b_e, write_data_e, alu_result_e;
  logic            zero_e;

  logic            reg_write_d, reg_write_q;
  logic            mem_write_d, mem_write_q;
  logic [1:0]      result_src_d, result_src_q;
  logic [XLEN-1:0] alu_result_d, alu_result_q;
  logic [XLEN-1:0] write_data_d, write_data_q;
  logic [XLEN-1:0] pc_plus4_d, pc_plus4_q;
  logic [4:0]      rd_d, rd_q;

  // M-stage forward source is the registered result of the previous instruction.
  always_comb begin
    case (ex.ForwardAE)
      FWD_W:   src_a_e = ex.ResultW;
      FWD_M:   src_a_e = alu_result_q;
      default: src_a_e = ex.RD1E;
    endcase
    case (ex.ForwardBE)
      FWD_W:   write_data_e = ex.ResultW;
      FWD_M:   write_data_e = alu_result_q;
      default: write_data_e = ex.RD2E;
    endcase
  end

  assign src_b_e = ex.ALUSrcE ? ex.ImmExtE : write_data_e;

  alu #(.XLEN(XLEN)) u_alu (
    .SrcA       (src_a_e),
    .SrcB       (src_b_e),
    .ALUControl (ex.ALUControlE),
    .ALUResult  (alu_result_e),
    .Zero       (zero_e)
  );

  assign ex.PCTargetE = ex.PCE + ex.ImmExtE;
  assign ex.PCSrcE    = ex.JumpE | (ex.BranchE & zero_e);

  always_comb begin
    reg_write_d  = 1'b0;
    mem_write_d  = 1'b0;
    result_src_d = '0;
    alu_result_d = '0;
    write_data_d = '0;
    pc_plus4_d   = '0;
    rd_d         = '0;
    if (!ex.FlushM) begin
      reg_write_d  = ex.RegWriteE;
      mem_write_d  = ex.MemWriteE;
      result_src_d = ex.ResultSrcE;
      alu_result_d = alu_result_e;
      write_data_d = write_data_e;
      pc_plus4_d   = ex.PCPlus4E;
      rd_d         = ex.RdE;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
      rd_q         <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_plus4_q   <= pc_plus4_d;
      rd_q         <= rd_d;
    end
  end

  assign ex.RegWriteM  = reg_write_q;
  assign ex.MemWriteM  = mem_write_q;
  assign ex.ResultSrcM = result_src_q;
  assign ex.ALUResultM = alu_result_q;
  assign ex.WriteDataM = write_data_q;
  assign ex.PCPlus4M   = pc_plus4_q;
  assign ex.RdM        = rd_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed vector table, random vectors against a reference model, reset cases.
module tb_execute_stage;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  execute_stage_if #(.XLEN(32)) ifc ();

  execute_stage #(.XLEN(32)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .ex      (ifc)
  );

  typedef struct {
    logic        jump, branch, alusrc, memw, regw, flush;
    logic [1:0]  rsrc, fa, fb;
    logic [2:0]  aluc;
    logic [31:0] rd1, rd2, imm, pc, pc4, resw;
    logic [4:0]  rd;
    logic        e_pcsrc;
    logic [31:0] e_tgt, e_alu, e_wd;
  } vec_t;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] m_alu = '0;
  vec_t tbl[12];
  vec_t v;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf, input logic [31:0] w, input logic [31:0] m);
    if (sel == 2'd1) return w;
    if (sel == 2'd2) return m;
    return rf;
  endfunction

  // Fill expected fields from the architectural rules, using the model's copy of ALUResultM.
  function automatic vec_t model(input vec_t x, input logic [31:0] prev_m);
    logic [31:0] a, wd, b;
    a  = pick(x.fa, x.rd1, x.resw, prev_m);
    wd = pick(x.fb, x.rd2, x.resw, prev_m);
    b  = x.alusrc ? x.imm : wd;
    x.e_alu   = x.flush ? 32'd0 : alu_ref(x.aluc, a, b);
    x.e_wd    = x.flush ? 32'd0 : wd;
    x.e_tgt   = x.pc + x.imm;
    x.e_pcsrc = x.jump | (x.branch & (alu_ref(x.aluc, a, b) == 32'd0));
    return x;
  endfunction

  task automatic drive(input vec_t x);
    ifc.JumpE = x.jump;   ifc.BranchE = x.branch; ifc.ALUSrcE = x.alusrc;
    ifc.MemWriteE = x.memw; ifc.RegWriteE = x.regw; ifc.ResultSrcE = x.rsrc;
    ifc.ALUControlE = x.aluc; ifc.RD1E = x.rd1; ifc.RD2E = x.rd2;
    ifc.ImmExtE = x.imm; ifc.RdE = x.rd; ifc.PCE = x.pc; ifc.PCPlus4E = x.pc4;
    ifc.ForwardAE = x.fa; ifc.ForwardBE = x.fb; ifc.ResultW = x.resw; ifc.FlushM = x.flush;
  endtask

  task automatic run_check(input vec_t x);
    drive(x);
    #1;
    chk("PCSrcE", 32'(ifc.PCSrcE), 32'(x.e_pcsrc));
    chk("PCTargetE", ifc.PCTargetE, x.e_tgt);
    @(posedge CLK);
    #1;
    chk("RegWriteM", 32'(ifc.RegWriteM), x.flush ? 32'd0 : 32'(x.regw));
    chk("MemWriteM", 32'(ifc.MemWriteM), x.flush ? 32'd0 : 32'(x.memw));
    chk("ResultSrcM", 32'(ifc.ResultSrcM), x.flush ? 32'd0 : 32'(x.rsrc));
    chk("RdM", 32'(ifc.RdM), x.flush ? 32'd0 : 32'(x.rd));
    chk("PCPlus4M", ifc.PCPlus4M, x.flush ? 32'd0 : x.pc4);
    chk("ALUResultM", ifc.ALUResultM, x.e_alu);
    chk("WriteDataM", ifc.WriteDataM, x.e_wd);
    m_alu = x.e_alu;
  endtask

  task automatic chk_m_zero(input string tag);
    chk({tag, " RegWriteM"}, 32'(ifc.RegWriteM), 32'd0);
    chk({tag, " MemWriteM"}, 32'(ifc.MemWriteM), 32'd0);
    chk({tag, " ResultSrcM"}, 32'(ifc.ResultSrcM), 32'd0);
    chk({tag, " RdM"}, 32'(ifc.RdM), 32'd0);
    chk({tag, " PCPlus4M"}, ifc.PCPlus4M, 32'd0);
    chk({tag, " ALUResultM"}, ifc.ALUResultM, 32'd0);
    chk({tag, " WriteDataM"}, ifc.WriteDataM, 32'd0);
  endtask

  function automatic vec_t rand_vec();
    vec_t x;
    x.jump = ($urandom_range(0, 7) == 0); x.branch = $urandom_range(0, 1) == 1;
    x.alusrc = $urandom_range(0, 1) == 1; x.memw = $urandom_range(0, 1) == 1;
    x.regw = $urandom_range(0, 1) == 1; x.flush = ($urandom_range(0, 7) == 0);
    x.rsrc = 2'($urandom_range(0, 3)); x.fa = 2'($urandom_range(0, 3));
    x.fb = 2'($urandom_range(0, 3)); x.aluc = 3'($urandom_range(0, 7));
    x.rd1 = $urandom; x.rd2 = ($urandom_range(0, 3) == 0) ? x.rd1 : $urandom;
    x.imm = $urandom; x.pc = $urandom; x.pc4 = $urandom; x.resw = $urandom;
    x.rd = 5'($urandom_range(0, 31));
    x.e_pcsrc = 1'b0; x.e_tgt = '0; x.e_alu = '0; x.e_wd = '0;
    return x;
  endfunction

  function automatic vec_t blank();
    vec_t x;
    x = '{jump: 1'b0, branch: 1'b0, alusrc: 1'b0, memw: 1'b0, regw: 1'b0, flush: 1'b0,
          rsrc: 2'd0, fa: 2'd0, fb: 2'd0, aluc: 3'd0, rd1: '0, rd2: '0, imm: '0, pc: '0,
          pc4: '0, resw: '0, rd: '0, e_pcsrc: 1'b0, e_tgt: '0, e_alu: '0, e_wd: '0};
    return x;
  endfunction

  initial begin
    // Directed table; expected values worked out by hand.
    v = blank(); v.alusrc = 1; v.rd1 = 32'h10; v.rd2 = 32'h3; v.imm = 32'hFFFF_FFFC; v.regw = 1; v.rd = 5;
      v.pc = 32'h40; v.pc4 = 32'h44; v.e_tgt = 32'h3C; v.e_alu = 32'h0C; v.e_wd = 32'h3; tbl[0] = v;
    v = blank(); v.branch = 1; v.aluc = 1; v.rd1 = 7; v.rd2 = 7; v.pc = 32'h100; v.imm = 32'h20;
      v.e_pcsrc = 1; v.e_tgt = 32'h120; v.e_alu = 0; v.e_wd = 7; tbl[1] = v;
    v = blank(); v.branch = 1; v.aluc = 1; v.rd1 = 7; v.rd2 = 8; v.pc = 32'h100; v.imm = 32'h20;
      v.e_pcsrc = 0; v.e_tgt = 32'h120; v.e_alu = 32'hFFFF_FFFF; v.e_wd = 8; tbl[2] = v;
    v = blank(); v.regw = 1; v.rd = 3; v.rd1 = 32'h50; v.rd2 = 5; v.rsrc = 2'b10; v.pc4 = 32'h8;
      v.e_alu = 32'h55; v.e_wd = 5; tbl[3] = v;
    v = blank(); v.fa = 2'b10; v.fb = 2'b01; v.aluc = 3; v.resw = 32'hAA; v.rd1 = 32'h1234; v.rd2 = 32'h5678;
      v.pc = 32'h200; v.imm = 4; v.memw = 1; v.e_tgt = 32'h204; v.e_alu = 32'hFF; v.e_wd = 32'hAA; tbl[4] = v;
    v = blank(); v.aluc = 5; v.rd1 = 32'hFFFF_FFFF; v.rd2 = 1; v.e_alu = 1; v.e_wd = 1; tbl[5] = v;
    v = blank(); v.aluc = 5; v.rd1 = 1; v.rd2 = 32'hFFFF_FFFF; v.e_alu = 0; v.e_wd = 32'hFFFF_FFFF; tbl[6] = v;
    v = blank(); v.aluc = 1; v.rd1 = 0; v.rd2 = 1; v.e_alu = 32'hFFFF_FFFF; v.e_wd = 1; tbl[7] = v;
    v = blank(); v.fa = 2'b11; v.fb = 2'b11; v.aluc = 2; v.rd1 = 32'hF0F0; v.rd2 = 32'hFF00; v.resw = 32'h1;
      v.e_alu = 32'hF000; v.e_wd = 32'hFF00; tbl[8] = v;
    v = blank(); v.branch = 1; v.aluc = 7; v.rd1 = 5; v.rd2 = 6; v.pc = 32'h10; v.imm = 8;
      v.e_pcsrc = 1; v.e_tgt = 32'h18; v.e_alu = 0; v.e_wd = 6; tbl[9] = v;
    v = blank(); v.jump = 1; v.memw = 1; v.regw = 1; v.rd = 9; v.flush = 1; v.rd1 = 3; v.rd2 = 4;
      v.pc = 32'h300; v.imm = 32'h10; v.pc4 = 32'h304; v.e_pcsrc = 1; v.e_tgt = 32'h310; tbl[10] = v;
    v = blank(); v.fa = 2'b10; v.rd1 = 32'h77; v.rd2 = 3; v.pc = 32'hFFFF_FFF0; v.imm = 32'h20;
      v.e_tgt = 32'h10; v.e_alu = 3; v.e_wd = 3; tbl[11] = v;

    // Reset held with live inputs and running clock.
    v = rand_vec(); v.jump = 1; v.flush = 0;
    drive(v);
    repeat (3) @(posedge CLK);
    #1;
    chk_m_zero("rst");
    chk("rst PCSrcE", 32'(ifc.PCSrcE), 32'd1);
    chk("rst PCTargetE", ifc.PCTargetE, v.pc + v.imm);
    v = blank(); v.regw = 1; v.rd = 5'h1A; v.rd1 = 1; v.rd2 = 2; v.pc4 = 32'h1234;
    RESET_N = 1'b1;
    m_alu = '0;
    run_check(model(v, m_alu));

    foreach (tbl[i]) run_check(tbl[i]);

    for (int i = 0; i < 300; i++) run_check(model(rand_vec(), m_alu));

    // Asynchronous reset between edges wipes captured state at once.
    v = blank(); v.regw = 1; v.memw = 1; v.rd = 3; v.rd1 = 1; v.rd2 = 1; v.pc4 = 32'h44;
    run_check(model(v, m_alu));
    #2 RESET_N = 1'b0;
    #1 chk_m_zero("async");
    #1 RESET_N = 1'b1;
    m_alu = '0;
    v = blank(); v.fa = 2'b10; v.rd1 = 32'h99; v.rd2 = 32'h7; v.regw = 1; v.rd = 4;
    run_check(model(v, m_alu));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Consumer side of the ID/EX pipeline interface. Takes the registered control signals, operands, immediate, Rd and PC values produced by the decode stage.
- Performs the ALU operation, with operand forwarding from the M and W stages.
- Resolves branch/jump and returns PCSrcE/PCTargetE to fetch.
- Holds the EX/MEM pipeline register that feeds the memory stage.

Parameters:
- XLEN, 32, datapath width of operands, PC and results.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET_N  input  1  asynchronous, active-low reset; clears EX/MEM register.
- JumpE, BranchE, ALUSrcE, MemWriteE, RegWriteE  input  1 each  ID/EX control.
- ResultSrcE  input  2  result select carried to M/W (00 ALU, 01 mem, 10 PC+4).
- ALUControlE  input  3  ALU operation.
- RD1E, RD2E  input  XLEN  register-file operands.
- ImmExtE  input  XLEN  sign-extended immediate.
- RdE  input  5  destination register.
- PCE, PCPlus4E  input  XLEN  PC and PC+4 of the instruction in E.
- ForwardAE, ForwardBE  input  2  operand select: 00 RDxE, 01 ResultW, 10 ALUResultM, 11 treated as 00.
- ResultW  input  XLEN  writeback value for forwarding.
- FlushM  input  1  synchronous bubble insert into EX/MEM.
- PCSrcE  output  1  redirect fetch (combinational).
- PCTargetE  output  XLEN  redirect target (combinational).
- RegWriteM, MemWriteM  output  1 each  registered control.
- ResultSrcM  output  2  registered result select.
- ALUResultM  output  XLEN  registered ALU result; also the internal forward source.
- WriteDataM  output  XLEN  registered store data (forwarded B before ALUSrc mux).
- RdM  output  5  registered destination.
- PCPlus4M  output  XLEN  registered PC+4.

Behaviour:
- Reset: RESET_N low asynchronously forces all M outputs to 0. These outputs stay 0 until the first rising CLK edge after RESET_N deasserts. PCSrcE and PCTargetE remain combinational from inputs throughout.
- Operand A:
  - SrcAE = mux(ForwardAE).
- Operand B:
  - WriteDataE = mux(ForwardBE).
  - SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
- ALU, by ALUControlE:
  - 000 add; 001 sub; 010 and; 011 or.
  - 101 slt: signed compare, result 1 or 0 zero-extended.
  - All other codes give 0.
  - Add and sub wrap modulo 2^XLEN; there are no overflow flags.
- ZeroE = (ALUResult == 0).
- PCTargetE = PCE + ImmExtE, modulo 2^XLEN.
- PCSrcE = JumpE | (BranchE & ZeroE). Branch is beq-only semantics.
- Latency: redirect is resolved in the same cycle as E. All M outputs appear exactly 1 cycle after E inputs.
- EX/MEM register, each rising edge:
  - FlushM=1: RegWriteM=0, MemWriteM=0, ResultSrcM=00, RdM=0, ALUResultM=0, WriteDataM=0, PCPlus4M=0.
  - Otherwise: all M outputs capture the E-stage values.
- FlushM simultaneous with valid E inputs: flush wins and the instruction is dropped. PCSrcE is still driven that cycle; the hazard unit owns the consequences.
- Forwarding from ALUResultM uses the currently registered value, i.e. the previous instruction.
- Forward select 11 behaves as 00.
- Reset asserted mid-operation discards the in-flight EX/MEM contents immediately, without waiting for a clock edge.
- No stall input. E is never held; decode holds and flushes its own register.

Decomposition:
- Shared package (rv_pipe_pkg):
  - ALU op constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT).
  - ResultSrc encodings.
  - Forward-select encodings (FWD_RF, FWD_W, FWD_M).
- One sub-module, alu:
  - Inputs: SrcA, SrcB, ALUControl.
  - Outputs: ALUResult, Zero.
  - Combinational.
- Forwarding muxes, target adder and EX/MEM register stay in execute_stage.

Test Plan:
1. Reset: hold RESET_N=0, drive arbitrary E inputs with clock running -> all M outputs 0. After release, first edge captures inputs.
2. Add with immediate: ALUSrcE=1, ALUControlE=000, RD1E=0x10, ImmExtE=0xFFFFFFFC, RegWriteE=1, RdE=5 -> next cycle ALUResultM=0x0C, RdM=5, RegWriteM=1.
3. Branch taken and not taken: BranchE=1, ALUControlE=001.
   - RD1E=RD2E=7, PCE=0x100, ImmExtE=0x20 -> same cycle PCSrcE=1, PCTargetE=0x120.
   - RD2E=8 -> PCSrcE=0.
4. Forwarding: ALUResultM=0x55 from a prior add, ResultW=0xAA.
   - ForwardAE=10, ForwardBE=01, ALUControlE=011 -> ALUResultM next = 0xFF.
   - WriteDataM = 0xAA.
5. slt signed: RD1E=0xFFFFFFFF, RD2E=1, ALUControlE=101 -> ALUResultM=1. Swap operands -> 0. Separately, a sub wrapping 0-1 gives ALUResultM=0xFFFFFFFF.
6. Flush and jump: JumpE=1, MemWriteE=1, FlushM=1 -> PCSrcE=1 that cycle; next cycle MemWriteM=0, RegWriteM=0, RdM=0. An async RESET_N pulse mid-stream clears M outputs before the next edge.
